// File: rtl/rtan_sweep_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rtan_sweep_sequencer_pkg
// Shared types and constants for the |r*tan(theta)| sweep sequencer.
//   state_t           FSM state encoding
//   LAST_ANGLE_INDEX  index of the final (75 deg) item
//   ANGLE_STEP_DEG    degrees per angle index
//   TANxx_Q8          tan(theta) scaled by 256, rounded to nearest
//   scale_trunc()     floor(mag * coef / 256), kept to 8 bits
// -----------------------------------------------------------------------------
package rtan_sweep_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [2:0] LAST_ANGLE_INDEX = 3'd5;
    localparam logic [6:0] ANGLE_STEP_DEG   = 7'd15;

    localparam logic [9:0] TAN15_Q8 = 10'd69;
    localparam logic [9:0] TAN30_Q8 = 10'd148;
    localparam logic [9:0] TAN45_Q8 = 10'd256;
    localparam logic [9:0] TAN60_Q8 = 10'd443;
    localparam logic [9:0] TAN75_Q8 = 10'd955;

    // Upper bits beyond 8 are dropped on purpose: the result wraps rather
    // than saturating.
    function automatic logic [7:0] scale_trunc(input logic [8:0] mag,
                                               input logic [9:0] coef);
        logic [18:0] prod;
        prod = {10'd0, mag} * {9'd0, coef};
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/rtan_sweep_sequencer_calc.sv
// -----------------------------------------------------------------------------
// calc_abs7rtan_00_75_15
// Combinational |r * tan(theta)| for theta = 0,15,30,45,60,75 deg.
// Ports:
//   i_r             in  9  signed radius
//   o_abs7rtan_00   out 8  |r*tan 0|  (always 0)
//   o_abs7rtan_15   out 8  |r*tan 15| truncated to 8 bits
//   o_abs7rtan_30   out 8  |r*tan 30| truncated to 8 bits
//   o_abs7rtan_45   out 8  |r|        truncated to 8 bits
//   o_abs7rtan_60   out 8  |r*tan 60| truncated to 8 bits
//   o_abs7rtan_75   out 8  |r*tan 75| truncated to 8 bits
// -----------------------------------------------------------------------------
module calc_abs7rtan_00_75_15
    import rtan_sweep_sequencer_pkg::*;
(
    input  logic signed [8:0] i_r,
    output logic [7:0]        o_abs7rtan_00,
    output logic [7:0]        o_abs7rtan_15,
    output logic [7:0]        o_abs7rtan_30,
    output logic [7:0]        o_abs7rtan_45,
    output logic [7:0]        o_abs7rtan_60,
    output logic [7:0]        o_abs7rtan_75
);

    logic [8:0] w_r_bits;
    logic [8:0] w_mag;

    assign w_r_bits = i_r;
    // 9-bit unsigned magnitude; -256 maps to 256 without overflow.
    assign w_mag = w_r_bits[8] ? (9'd0 - w_r_bits) : w_r_bits;

    assign o_abs7rtan_00 = 8'd0;
    assign o_abs7rtan_15 = scale_trunc(w_mag, TAN15_Q8);
    assign o_abs7rtan_30 = scale_trunc(w_mag, TAN30_Q8);
    assign o_abs7rtan_45 = scale_trunc(w_mag, TAN45_Q8);
    assign o_abs7rtan_60 = scale_trunc(w_mag, TAN60_Q8);
    assign o_abs7rtan_75 = scale_trunc(w_mag, TAN75_Q8);

endmodule

// File: rtl/rtan_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// rtan_sweep_sequencer
// Captures a radius on start, waits for the rtan path to settle, then streams
// six angle-tagged |r*tan(theta)| results over a ready/valid interface.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// SETTLE  | r captured, counting SETTLE_CYCLES before first sample
// PRESENT | current item valid, advancing on each handshake
// DONE    | one-cycle done pulse; start here launches the next sweep
//
// Ports:
//   clock           in  1  system clock
//   reset           in  1  synchronous active-high reset
//   start           in  1  sweep request, level-sampled
//   r               in  9  signed radius, captured on accepted start
//   out_valid       out 1  item valid
//   out_ready       in  1  consumer accepts item
//   out_value       out 8  |r*tan theta| truncated to 8 bits
//   out_angle_index out 3  0..5
//   out_angle_deg   out 7  index*15
//   out_last        out 1  valid item at index 5
//   busy            out 1  SETTLE or PRESENT
//   done            out 1  pulse after final handshake
//   start_dropped   out 1  start seen while busy
// -----------------------------------------------------------------------------
module rtan_sweep_sequencer
    import rtan_sweep_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic signed [8:0] r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_value,
    output logic [2:0]        out_angle_index,
    output logic [6:0]        out_angle_deg,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              start_dropped
);

    localparam logic [3:0] SETTLE_MATCH = 4'(SETTLE_CYCLES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic signed [8:0] r_r_reg;
    logic signed [8:0] w_r_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [7:0]        r_out_value;
    logic [7:0]        w_value_nxt;

    logic [7:0] w_rtan_00;
    logic [7:0] w_rtan_15;
    logic [7:0] w_rtan_30;
    logic [7:0] w_rtan_45;
    logic [7:0] w_rtan_60;
    logic [7:0] w_rtan_75;
    logic [2:0] w_sel;
    logic [7:0] w_sel_value;

    calc_abs7rtan_00_75_15 u_calc (
        .i_r           (r_r_reg),
        .o_abs7rtan_00 (w_rtan_00),
        .o_abs7rtan_15 (w_rtan_15),
        .o_abs7rtan_30 (w_rtan_30),
        .o_abs7rtan_45 (w_rtan_45),
        .o_abs7rtan_60 (w_rtan_60),
        .o_abs7rtan_75 (w_rtan_75)
    );

    // SETTLE loads the current index; PRESENT preloads the next one so the
    // value updates on the same edge as the index.
    assign w_sel = (r_state == ST_PRESENT) ? (r_idx + 3'd1) : r_idx;

    always_comb begin
        w_sel_value = 8'd0;
        case (w_sel)
            3'd0:    w_sel_value = w_rtan_00;
            3'd1:    w_sel_value = w_rtan_15;
            3'd2:    w_sel_value = w_rtan_30;
            3'd3:    w_sel_value = w_rtan_45;
            3'd4:    w_sel_value = w_rtan_60;
            3'd5:    w_sel_value = w_rtan_75;
            default: w_sel_value = 8'd0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_r_nxt       = r_r_reg;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_value_nxt   = r_out_value;
        out_valid     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        start_dropped = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                done        = (r_state == ST_DONE);
                w_state_nxt = ST_IDLE;
                if (start) begin
                    w_r_nxt     = r;
                    w_idx_nxt   = 3'd0;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy          = 1'b1;
                start_dropped = start;
                if (r_cnt == SETTLE_MATCH) begin
                    w_value_nxt = w_sel_value;
                    w_state_nxt = ST_PRESENT;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_PRESENT: begin
                busy          = 1'b1;
                out_valid     = 1'b1;
                start_dropped = start;
                if (out_ready) begin
                    if (r_idx == LAST_ANGLE_INDEX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_value_nxt = w_sel_value;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_r_reg     <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_out_value <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_r_reg     <= w_r_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_value <= w_value_nxt;
        end
    end

    assign out_value       = r_out_value;
    assign out_angle_index = r_idx;
    assign out_angle_deg   = {4'd0, r_idx} * ANGLE_STEP_DEG;
    assign out_last        = out_valid & (r_idx == LAST_ANGLE_INDEX);

endmodule
